branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, serving the IF stage of the pipelined CPU.
- Gives a next-PC prediction each cycle from the fetch PC.
- Is trained by the branch resolution result from the EX stage.
- Detects mispredictions and drives the pipeline flush/redirect, plus a saturating mispredict counter for performance monitoring.

Parameters:
- IDX_W, 4, index width; table has 2**IDX_W entries.
- XLEN, 32, PC/target width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  fetch-stage PC.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  XLEN  predicted target when pred_taken=1, else if_pc+4.
- ex_valid  in  1  EX stage holds a resolving conditional branch or jal/jalr.
- ex_stall  in  1  EX held by hazard unit; suppresses update and redirect.
- ex_pc  in  XLEN  PC of the resolving instruction.
- ex_taken  in  1  resolved direction (Branch result, forced 1 for jumps).
- ex_target  in  XLEN  resolved taken target.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- redirect  out  1  mispredict; IF/ID/EX-front must flush (combinational).
- redirect_pc  out  XLEN  correct next PC when redirect=1.
- mispredict_cnt  out  16  saturating mispredict count.

Behaviour:
- Each entry holds: valid, tag (XLEN-IDX_W-2 bits), target (XLEN), ctr (2 bits).
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Reset (async, any time including mid-update):
  - all valid=0, all ctr=2'b01, mispredict_cnt=0.
  - Outputs while reset is high: pred_taken=0, pred_target=if_pc+4, redirect=0.
- Prediction (0-cycle latency):
  - hit = valid & tag match on if_pc.
  - pred_taken = hit & ctr[1]; pred_target = pred_taken ? target : if_pc+4.
- Update enable: upd = ex_valid & ~ex_stall. When upd=0, no state changes.
- On rising edge with upd=1, for ex_pc:
  - hit, ex_taken=1: ctr=sat_inc(ctr) (max 2'b11), target=ex_target.
  - hit, ex_taken=0: ctr=sat_dec(ctr) (min 2'b00); target and valid unchanged.
  - miss, ex_taken=1: allocate/replace; valid=1, tag, target=ex_target, ctr=2'b10.
  - miss, ex_taken=0: no change (no allocation).
- mispredict = upd & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
- redirect = mispredict (combinational).
- redirect_pc = ex_taken ? ex_target : ex_pc+4. When redirect=0, redirect_pc = ex_pc+4 (don't-care).
- mispredict_cnt increments on each edge with mispredict=1 and saturates at 16'hFFFF.
- Same-cycle read/write of the same index: if_pc sees the pre-update contents; the new value is visible the next cycle.
- PC+4 wraps modulo 2**XLEN (0xFFFFFFFC+4 = 0).
- Aliasing: a different tag on the same index is a miss. Replacement only on a taken miss.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104. Assert reset mid-run with entries valid -> next lookup misses.
- EX: ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 -> same cycle redirect=1, redirect_pc=0x80, mispredict_cnt=1. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Resolve 0x100 taken ×3 then not-taken ×1 -> ctr goes 10→11→11→10; prediction stays taken. A second not-taken -> ctr=01, prediction not-taken.
- Alias: 0x100 allocated; then ex_pc=0x140 taken to 0x200 (IDX_W=4, same index) -> lookup of 0x100 misses, lookup of 0x140 hits with target 0x200.
- ex_valid=1 with ex_stall=1 and a wrong prediction -> redirect=0, table and counter unchanged. Drop the stall -> redirect=1.
- Preload mispredict_cnt to 16'hFFFF via repeated mispredicts (or force) -> one further mispredict keeps it at 16'hFFFF. Also check ex_pc=0xFFFFFFFC not-taken, mispredicted -> redirect_pc=0x0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Predicts the next fetch PC combinationally and is trained by EX-stage branch resolution.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [15:0]     mispredict_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]  tgt_q;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  logic             mispredict;
  logic [1:0]       ex_ctr;

  // Fetch-side lookup
  always_comb begin
    if_idx      = if_pc[IDX_W+1:2];
    if_tag      = if_pc[XLEN-1:IDX_W+2];
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = ~reset & if_hit & ctr_q[if_idx][1];
    pred_target = pred_taken ? tgt_q[if_idx] : if_pc + PC_STEP;
  end

  // Resolution side: training lookup and misprediction detection
  always_comb begin
    ex_idx      = ex_pc[IDX_W+1:2];
    ex_tag      = ex_pc[XLEN-1:IDX_W+2];
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_ctr      = ctr_q[ex_idx];
    upd         = ex_valid & ~ex_stall;
    mispredict  = upd & ((ex_taken != ex_pred_taken) |
                         (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
    redirect    = mispredict & ~reset;
    redirect_pc = ex_taken ? ex_target : ex_pc + PC_STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ctr_q   <= {ENTRIES{2'b01}};
    end else if (upd) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (ex_ctr != 2'b11) ctr_q[ex_idx] <= ex_ctr + 2'b01;
        end else if (ex_ctr != 2'b00) begin
          ctr_q[ex_idx] <= ex_ctr - 2'b01;
        end
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target storage needs no reset: contents are only visible through valid_q
  always_ff @(posedge clk) begin
    if (upd && ex_taken) begin
      tgt_q[ex_idx] <= ex_target;
      if (!ex_hit) tag_q[ex_idx] <= ex_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_cnt <= '0;
    end else if (mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural BTB model held in plain arrays.
module tb_branch_predictor;
  localparam int IDX_W = 4;
  localparam int XLEN  = 32;
  localparam int N     = 1 << IDX_W;
  localparam int SH    = IDX_W + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_stall, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: each slot remembers the PC that owns it and a strength 0..3
  bit          m_valid[N];
  logic [31:0] m_owner[N];
  logic [31:0] m_tgt[N];
  int          m_ctr[N];
  int          m_cnt;

  branch_predictor #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) & (N - 1));
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && ((m_owner[i] >> SH) == (pc >> SH));
  endfunction

  function automatic bit m_pred_taken(logic [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    if (!(ex_valid && !ex_stall)) return 1'b0;
    return (ex_taken != ex_pred_taken) ||
           (ex_taken && ex_pred_taken && ex_target != ex_pred_target);
  endfunction

  function automatic logic [31:0] m_redirect_pc();
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_cnt = 0;
  endtask

  task automatic model_update();
    int i;
    if (!(ex_valid && !ex_stall)) return;
    if (m_mispredict() && m_cnt < 65535) m_cnt++;
    i = m_idx(ex_pc);
    if (m_hit(ex_pc)) begin
      if (ex_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = ex_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (ex_taken) begin
      m_valid[i] = 1'b1;
      m_owner[i] = ex_pc;
      m_tgt[i]   = ex_target;
      m_ctr[i]   = 2;
    end
  endtask

  // Advance one clock edge with the current inputs; returns 1 time unit after the edge
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic s, input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_stall = s; ex_pc = pc; ex_taken = t;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    if_pc = 32'h100;
    set_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    total_cnt++;
    if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b expected 0", pred_taken);
    else pass_cnt++;
    total_cnt++;
    if (pred_target !== 32'h104) $display("FAIL reset_pred_target: got %h expected 00000104", pred_target);
    else pass_cnt++;
    total_cnt++;
    if (redirect !== 1'b0) $display("FAIL reset_redirect: got %b expected 0", redirect);
    else pass_cnt++;
    total_cnt++;
    if (mispredict_cnt !== 16'h0) $display("FAIL reset_cnt: got %h expected 0000", mispredict_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic test_allocate();
    if_pc = 32'h100;
    set_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h80)
      $display("FAIL alloc_redirect: got %b/%h expected 1/00000080", redirect, redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if (pred_taken !== 1'b0) $display("FAIL alloc_same_cycle_read: got %b expected 0", pred_taken);
    else pass_cnt++;
    tick();
    ex_valid = 1'b0;
    #1;
    total_cnt++;
    if (mispredict_cnt !== 16'd1) $display("FAIL alloc_cnt: got %0d expected 1", mispredict_cnt);
    else pass_cnt++;
    total_cnt++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80)
      $display("FAIL alloc_lookup: got %b/%h expected 1/00000080", pred_taken, pred_target);
    else pass_cnt++;
  endtask

  task automatic test_counter();
    bit exp_t[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit dir[5]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    if_pc = 32'h100;
    for (int k = 0; k < 5; k++) begin
      set_ex(1'b1, 1'b0, 32'h100, dir[k], 32'h80, 1'b1, 32'h80);
      tick();
      ex_valid = 1'b0;
      #1;
      total_cnt++;
      if (pred_taken !== exp_t[k] || pred_target !== (exp_t[k] ? 32'h80 : 32'h104))
        $display("FAIL counter_step%0d: got %b/%h expected %b/%h", k, pred_taken, pred_target,
                 exp_t[k], exp_t[k] ? 32'h80 : 32'h104);
      else pass_cnt++;
    end
    total_cnt++;
    if (mispredict_cnt !== 16'd3) $display("FAIL counter_cnt: got %0d expected 3", mispredict_cnt);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
      tick();
    end
    set_ex(1'b1, 1'b0, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    tick();
    ex_valid = 1'b0;
    if_pc = 32'h100;
    #1;
    total_cnt++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104)
      $display("FAIL alias_old_miss: got %b/%h expected 0/00000104", pred_taken, pred_target);
    else pass_cnt++;
    if_pc = 32'h140;
    #1;
    total_cnt++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200)
      $display("FAIL alias_new_hit: got %b/%h expected 1/00000200", pred_taken, pred_target);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int saved_cnt = m_cnt;
    if_pc = 32'h140;
    set_ex(1'b1, 1'b1, 32'h140, 1'b0, 32'h200, 1'b1, 32'h200);
    #1;
    total_cnt++;
    if (redirect !== 1'b0) $display("FAIL stall_redirect: got %b expected 0", redirect);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200 || mispredict_cnt !== 16'(saved_cnt))
      $display("FAIL stall_state: got %b/%h/%0d expected 1/00000200/%0d",
               pred_taken, pred_target, mispredict_cnt, saved_cnt);
    else pass_cnt++;
    ex_stall = 1'b0;
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h144)
      $display("FAIL unstall_redirect: got %b/%h expected 1/00000144", redirect, redirect_pc);
    else pass_cnt++;
    tick();
    ex_valid = 1'b0;
    #1;
    total_cnt++;
    if (mispredict_cnt !== 16'(saved_cnt + 1))
      $display("FAIL unstall_cnt: got %0d expected %0d", mispredict_cnt, saved_cnt + 1);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] pool[8];
    logic [31:0] exp_v, got_v;
    logic [113:0] exp_all, got_all;
    pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h1104, 32'h3c, 32'h7c, 32'hFFFF_FFFC};
    for (int k = 0; k < 400; k++) begin
      if_pc    = pool[$urandom_range(0, 7)];
      ex_pc    = pool[$urandom_range(0, 7)];
      ex_valid = ($urandom_range(0, 9) < 8);
      ex_stall = ($urandom_range(0, 3) == 0);
      ex_taken = $urandom_range(0, 1);
      ex_target = pool[$urandom_range(0, 7)] + 32'h40;
      if ($urandom_range(0, 1) == 1) begin
        ex_pred_taken  = m_pred_taken(ex_pc);
        ex_pred_target = m_pred_target(ex_pc);
      end else begin
        ex_pred_taken  = $urandom_range(0, 1);
        ex_pred_target = pool[$urandom_range(0, 7)] + 32'h40;
      end
      #1;
      exp_v   = m_mispredict() ? m_redirect_pc() : 32'h0;
      got_v   = redirect ? redirect_pc : 32'h0;
      exp_all = {m_pred_taken(if_pc), m_pred_target(if_pc), m_mispredict(), exp_v, 16'(m_cnt)};
      got_all = {pred_taken, pred_target, redirect, got_v, mispredict_cnt};
      total_cnt++;
      if (got_all !== exp_all)
        $display("FAIL random_%0d: got %h expected %h (if_pc %h ex_pc %h)",
                 k, got_all, exp_all, if_pc, ex_pc);
      else pass_cnt++;
      tick();
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_ex(1'b1, 1'b0, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
    tick();
    if_pc = 32'h500;
    #1;
    total_cnt++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h600)
      $display("FAIL premid_lookup: got %b/%h expected 1/00000600", pred_taken, pred_target);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total_cnt++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h504 || redirect !== 1'b0 || mispredict_cnt !== 16'h0)
      $display("FAIL midreset_out: got %b/%h/%b/%h expected 0/00000504/0/0000",
               pred_taken, pred_target, redirect, mispredict_cnt);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    #1;
    total_cnt++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h504)
      $display("FAIL postreset_lookup: got %b/%h expected 0/00000504", pred_taken, pred_target);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    if_pc = 32'hFFFF_FFFC;
    set_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    total_cnt++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0)
      $display("FAIL wrap_redirect: got %b/%h expected 1/00000000", redirect, redirect_pc);
    else pass_cnt++;
    total_cnt++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL wrap_pred_target: got %b/%h expected 0/00000000", pred_taken, pred_target);
    else pass_cnt++;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_saturate();
    set_ex(1'b1, 1'b0, 32'h7000, 1'b0, 32'h0, 1'b1, 32'h8000);
    repeat (65534 - m_cnt) tick();
    total_cnt++;
    if (mispredict_cnt !== 16'hFFFE) $display("FAIL sat_pre: got %h expected fffe", mispredict_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mispredict_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h expected ffff", mispredict_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mispredict_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", mispredict_cnt);
    else pass_cnt++;
    ex_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_stall();
    test_random();
    test_reset_mid();
    test_wrap();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
